// File: rtl/call_return_unit_pkg.sv
// Shared widths and FSM encoding for the call/return sequencer and its stack bus.
// Defaults match the core's data word, flag field and hardware return-stack depth.
package call_return_unit_pkg;

    localparam int NUMBER_WIDTH_DATA_WIRE = 8;
    localparam int FLAG_LEN               = 4;
    localparam int STACK_LEN              = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PUSH = 2'd1;
    localparam logic [1:0] ST_POP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // A request is refused without touching the stack when the occupancy cannot move that way.
    function automatic logic req_rejected(input logic is_call, input logic full, input logic empty);
        return is_call ? full : empty;
    endfunction

endpackage

// File: rtl/call_return_unit_if.sv
// Control-unit side of the call/return sequencer: request handshake, captured
// return word and occupancy/error status.
interface call_return_unit_if
    import call_return_unit_pkg::*;
#(
    parameter int DATA_W = NUMBER_WIDTH_DATA_WIRE,
    parameter int FLAG_W = FLAG_LEN,
    parameter int CNT_W  = $clog2(STACK_LEN + 1)
);
    logic              call_req;
    logic              ret_req;
    logic [DATA_W-1:0] pc_in;
    logic [FLAG_W-1:0] flag_in;
    logic              err_clr;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] pc_out;
    logic [FLAG_W-1:0] flag_out;
    logic              pc_valid;
    logic [CNT_W-1:0]  depth;
    logic              overflow;
    logic              underflow;

    modport master (
        output call_req, ret_req, pc_in, flag_in, err_clr,
        input  busy, done, pc_out, flag_out, pc_valid, depth, overflow, underflow
    );

    modport slave (
        input  call_req, ret_req, pc_in, flag_in, err_clr,
        output busy, done, pc_out, flag_out, pc_valid, depth, overflow, underflow
    );
endinterface

// File: rtl/call_return_unit_stack_depth_counter.sv
// Saturating up/down occupancy counter mirroring the return stack pointer.
// Shares the stack's asynchronous active-low reset so both start empty together.
module stack_depth_counter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && !dec && (count_reg != DEPTH_C)) begin
            count_next = count_reg + 1'b1;
        end else if (dec && !inc && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/call_return_unit.sv
// CALL/RET sequencer for the hardware return stack: pushes {flag, pc} on CALL,
// pops and returns it on RET, and tracks occupancy with sticky overflow/underflow.
module call_return_unit
    import call_return_unit_pkg::*;
#(
    parameter int DATA_W = NUMBER_WIDTH_DATA_WIRE,
    parameter int FLAG_W = FLAG_LEN,
    parameter int DEPTH  = STACK_LEN,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    call_return_unit_if.slave core,
    output logic              stk_push,
    output logic              stk_pop,
    inout  wire  [DATA_W-1:0] stk_data,
    inout  wire  [FLAG_W-1:0] stk_flag
);
    state_t            state_reg;
    state_t            state_next;
    logic              drive_load;
    logic              set_ovf;
    logic              set_unf;
    logic              bus_drive;

    logic [DATA_W-1:0] drive_data_reg;
    logic [FLAG_W-1:0] drive_flag_reg;
    logic [DATA_W-1:0] pc_out_reg;
    logic [FLAG_W-1:0] flag_out_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              pc_valid_reg;
    logic              push_reg;
    logic              pop_reg;
    logic              ovf_reg;
    logic              unf_reg;

    logic [CNT_W-1:0]  depth_count;
    logic              full;
    logic              empty;

    stack_depth_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_depth (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (state_reg == ST_PUSH),
        .dec   (state_reg == ST_POP),
        .count (depth_count),
        .full  (full),
        .empty (empty)
    );

    // Requests are only looked at in IDLE; CALL wins over a simultaneous RET.
    always_comb begin
        state_next = state_reg;
        drive_load = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (core.call_req) begin
                    if (req_rejected(1'b1, full, empty)) begin
                        set_ovf    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        drive_load = 1'b1;
                        state_next = ST_PUSH;
                    end
                end else if (core.ret_req) begin
                    if (req_rejected(1'b0, full, empty)) begin
                        set_unf    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_POP;
                    end
                end
            end
            ST_PUSH: state_next = ST_DONE;
            ST_POP:  state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg      <= ST_IDLE;
            drive_data_reg <= '0;
            drive_flag_reg <= '0;
            pc_out_reg     <= '0;
            flag_out_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            pc_valid_reg   <= 1'b0;
            push_reg       <= 1'b0;
            pop_reg        <= 1'b0;
            ovf_reg        <= 1'b0;
            unf_reg        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            busy_reg     <= (state_next != ST_IDLE);
            done_reg     <= (state_next == ST_DONE);
            pc_valid_reg <= (state_reg == ST_POP);
            push_reg     <= (state_next == ST_PUSH);
            pop_reg      <= (state_next == ST_POP);

            if (drive_load) begin
                drive_data_reg <= core.pc_in;
                drive_flag_reg <= core.flag_in;
            end

            if (state_reg == ST_POP) begin
                pc_out_reg   <= stk_data;
                flag_out_reg <= stk_flag;
            end

            if (set_ovf) begin
                ovf_reg <= 1'b1;
            end else if (core.err_clr) begin
                ovf_reg <= 1'b0;
            end

            if (set_unf) begin
                unf_reg <= 1'b1;
            end else if (core.err_clr) begin
                unf_reg <= 1'b0;
            end
        end
    end

    // The bus follows the state register directly so reset releases it immediately.
    assign bus_drive = (state_reg == ST_PUSH);
    assign stk_data  = bus_drive ? drive_data_reg : {DATA_W{1'bz}};
    assign stk_flag  = bus_drive ? drive_flag_reg : {FLAG_W{1'bz}};

    assign stk_push       = push_reg;
    assign stk_pop        = pop_reg;
    assign core.busy      = busy_reg;
    assign core.done      = done_reg;
    assign core.pc_valid  = pc_valid_reg;
    assign core.pc_out    = pc_out_reg;
    assign core.flag_out  = flag_out_reg;
    assign core.depth     = depth_count;
    assign core.overflow  = ovf_reg;
    assign core.underflow = unf_reg;

endmodule

// File: tb/tb_call_return_unit.sv
// Scoreboard bench for call_return_unit: directed CALL/RET sequences against a
// behavioural return stack, with a monitor checking strobes and done responses.
module tb_call_return_unit;
    localparam int DW = 8;
    localparam int FW = 4;
    localparam int DP = 4;
    localparam int CW = 3;
    localparam int WW = DW + FW;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    call_return_unit_if #(.DATA_W(DW), .FLAG_W(FW), .CNT_W(CW)) core ();
    logic          stk_push;
    logic          stk_pop;
    wire  [DW-1:0] stk_data;
    wire  [FW-1:0] stk_flag;

    call_return_unit #(.DATA_W(DW), .FLAG_W(FW), .DEPTH(DP), .CNT_W(CW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .core     (core),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_data (stk_data),
        .stk_flag (stk_flag)
    );

    // Behavioural return stack plus a probe driver used to show the DUT has released the bus.
    logic [WW-1:0] mem [DP];
    logic [2:0]    sp;
    logic [WW-1:0] top_word;
    logic          probe_en;
    logic [WW-1:0] probe_val;
    logic          tb_en;
    logic [WW-1:0] tb_val;

    always_comb top_word = (sp != 3'd0) ? mem[2'(sp - 3'd1)] : '0;
    assign tb_en  = stk_pop | probe_en;
    assign tb_val = stk_pop ? top_word : probe_val;
    assign stk_data = tb_en ? tb_val[DW-1:0]  : {DW{1'bz}};
    assign stk_flag = tb_en ? tb_val[WW-1:DW] : {FW{1'bz}};

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sp <= 3'd0;
        end else if (stk_push && sp < 3'(DP)) begin
            mem[sp[1:0]] <= {stk_flag, stk_data};
            sp <= sp + 3'd1;
        end else if (stk_pop && sp != 3'd0) begin
            sp <= sp - 3'd1;
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int           cyc;
        logic         valid;
        logic [DW-1:0] pc;
        logic [FW-1:0] flag;
        int           dep;
        logic         ovf;
        logic         unf;
    } done_t;

    typedef struct {
        logic          is_push;
        logic [WW-1:0] word;
        int            cyc;
    } strb_t;

    done_t dq[$];
    strb_t sq[$];

    logic [WW-1:0] exp_stack[$];
    logic [DW-1:0] last_pc   = '0;
    logic [FW-1:0] last_flag = '0;
    logic          exp_ovf   = 1'b0;
    logic          exp_unf   = 1'b0;

    done_t md;
    strb_t ms;

    // Monitor: every strobe and every done pulse consumes one scoreboard entry.
    always @(negedge CLK) begin
        if (RESET) begin
            if (stk_push || stk_pop) begin
                check("strobe_excl", 32'(stk_push & stk_pop), 32'd0);
                if (sq.size() == 0) begin
                    check("unexpected_strobe", 32'(sq.size()), 32'd1);
                end else begin
                    ms = sq.pop_front();
                    check("strobe_kind", 32'(stk_push), 32'(ms.is_push));
                    check("strobe_cycle", 32'(cyc), 32'(ms.cyc));
                    check(ms.is_push ? "push_bus" : "pop_bus", 32'({stk_flag, stk_data}), 32'(ms.word));
                    $display("[TB] strobe %s word=0x%03h cycle=%0d", ms.is_push ? "push" : "pop", {stk_flag, stk_data}, cyc);
                end
            end
            if (core.done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 32'(dq.size()), 32'd1);
                end else begin
                    md = dq.pop_front();
                    check("done_cycle", 32'(cyc), 32'(md.cyc));
                    check("pc_valid", 32'(core.pc_valid), 32'(md.valid));
                    check("pc_out", 32'(core.pc_out), 32'(md.pc));
                    check("flag_out", 32'(core.flag_out), 32'(md.flag));
                    check("depth", 32'(core.depth), 32'(md.dep));
                    check("overflow", 32'(core.overflow), 32'(md.ovf));
                    check("underflow", 32'(core.underflow), 32'(md.unf));
                    check("busy_done", 32'(core.busy), 32'd1);
                    $display("[TB] done valid=%0d pc=0x%02h flag=0x%0h depth=%0d ovf=%0d unf=%0d cycle=%0d",
                             core.pc_valid, core.pc_out, core.flag_out, core.depth,
                             core.overflow, core.underflow, cyc);
                end
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!core.done && n < 10);
        check("done_timeout", 32'(core.done), 32'd1);
    endtask

    task automatic do_call(input logic [DW-1:0] pc, input logic [FW-1:0] fl);
        int t0;
        t0 = cyc;
        core.call_req = 1'b1;
        core.pc_in    = pc;
        core.flag_in  = fl;
        if (exp_stack.size() == DP) begin
            exp_ovf = 1'b1;
            dq.push_back('{t0 + 1, 1'b0, last_pc, last_flag, DP, 1'b1, exp_unf});
        end else begin
            exp_stack.push_back({fl, pc});
            sq.push_back('{1'b1, {fl, pc}, t0 + 1});
            dq.push_back('{t0 + 2, 1'b0, last_pc, last_flag, exp_stack.size(), exp_ovf, exp_unf});
        end
        wait_done();
        core.call_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_ret();
        int t0;
        logic [WW-1:0] w;
        t0 = cyc;
        core.ret_req = 1'b1;
        if (exp_stack.size() == 0) begin
            exp_unf = 1'b1;
            dq.push_back('{t0 + 1, 1'b0, last_pc, last_flag, 0, exp_ovf, 1'b1});
        end else begin
            w = exp_stack.pop_back();
            sq.push_back('{1'b0, w, t0 + 1});
            last_pc   = w[DW-1:0];
            last_flag = w[WW-1:DW];
            dq.push_back('{t0 + 2, 1'b1, last_pc, last_flag, exp_stack.size(), exp_ovf, exp_unf});
        end
        wait_done();
        core.ret_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic clear_err();
        core.err_clr = 1'b1;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        @(negedge CLK);
        core.err_clr = 1'b0;
        check("err_clr_ovf", 32'(core.overflow), 32'd0);
        check("err_clr_unf", 32'(core.underflow), 32'd0);
        $display("[TB] err_clr overflow=%0d underflow=%0d", core.overflow, core.underflow);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        logic [WW-1:0] w;
        core.call_req = 1'b0;
        core.ret_req  = 1'b0;
        core.pc_in    = '0;
        core.flag_in  = '0;
        core.err_clr  = 1'b0;
        probe_en  = 1'b1;
        probe_val = 12'hA5C;

        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(core.busy), 32'd0);
        check("rst_done", 32'(core.done), 32'd0);
        check("rst_pc_valid", 32'(core.pc_valid), 32'd0);
        check("rst_push", 32'(stk_push), 32'd0);
        check("rst_pop", 32'(stk_pop), 32'd0);
        check("rst_ovf", 32'(core.overflow), 32'd0);
        check("rst_unf", 32'(core.underflow), 32'd0);
        check("rst_depth", 32'(core.depth), 32'd0);
        check("rst_pc_out", 32'(core.pc_out), 32'd0);
        check("rst_flag_out", 32'(core.flag_out), 32'd0);
        check("rst_bus_z", 32'({stk_flag, stk_data}), 32'h0A5C);
        $display("[TB] reset state checked");
        RESET = 1'b1;
        probe_en = 1'b0;
        @(negedge CLK);

        do_ret();
        clear_err();

        do_call(8'h3C, 4'h2);
        do_ret();

        for (int i = 0; i < DP; i++) begin
            do_call(8'(17 * (i + 1)), 4'(2 * i + 1));
        end
        check("depth_full", 32'(core.depth), 32'(DP));
        do_call(8'h55, 4'h9);
        clear_err();
        for (int i = 0; i < DP; i++) begin
            do_ret();
        end

        // CALL and RET together: CALL first, the still-held RET in the following IDLE cycle.
        t0 = cyc;
        core.call_req = 1'b1;
        core.ret_req  = 1'b1;
        core.pc_in    = 8'h66;
        core.flag_in  = 4'hA;
        exp_stack.push_back(12'hA66);
        sq.push_back('{1'b1, 12'hA66, t0 + 1});
        dq.push_back('{t0 + 2, 1'b0, last_pc, last_flag, 1, exp_ovf, exp_unf});
        w = exp_stack.pop_back();
        sq.push_back('{1'b0, w, t0 + 4});
        last_pc   = w[DW-1:0];
        last_flag = w[WW-1:DW];
        dq.push_back('{t0 + 5, 1'b1, last_pc, last_flag, 0, exp_ovf, exp_unf});
        wait_done();
        core.call_req = 1'b0;
        wait_done();
        core.ret_req = 1'b0;
        @(negedge CLK);

        // Reset while a PUSH is in flight, with one entry already on the stack.
        do_call(8'h12, 4'h4);
        t0 = cyc;
        core.call_req = 1'b1;
        core.pc_in    = 8'h77;
        core.flag_in  = 4'h3;
        sq.push_back('{1'b1, 12'h377, t0 + 1});
        @(negedge CLK);
        #2;
        probe_val = 12'h5A3;
        probe_en  = 1'b1;
        RESET     = 1'b0;
        #1;
        check("midrst_push", 32'(stk_push), 32'd0);
        check("midrst_bus_z", 32'({stk_flag, stk_data}), 32'h05A3);
        check("midrst_busy", 32'(core.busy), 32'd0);
        $display("[TB] reset asserted during push");
        core.call_req = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        probe_en = 1'b0;
        exp_stack.delete();
        last_pc   = '0;
        last_flag = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        @(negedge CLK);
        check("post_rst_depth", 32'(core.depth), 32'd0);
        check("post_rst_busy", 32'(core.busy), 32'd0);
        check("post_rst_pc_out", 32'(core.pc_out), 32'd0);

        do_ret();
        clear_err();
        do_call(8'hC3, 4'hF);
        do_ret();

        repeat (2) @(negedge CLK);
        check("sb_done_left", 32'(dq.size()), 32'd0);
        check("sb_strobe_left", 32'(sq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
